// File: rtl/alu_responder.sv
// alu_responder: handshaked ALU (ADD / XOR / MUL / AND) with a 2*WIDTH result.
// ADD, XOR and AND complete in one cycle. MUL runs an iterative shift-add
// over WIDTH EXEC cycles, unless ALU_RESPONDER_FAST_MUL_EN is defined. In
// that case a combinational multiplier gives MUL the same one-cycle latency.
module alu_responder #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic [1:0]         result_op
);

    localparam int        CW     = $clog2(WIDTH + 1);
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_XOR = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t             state, state_nx;
    logic               accept;
    logic               mul_iter;    // accepted op takes the iterative path
    logic               last_step;
    logic [2*WIDTH-1:0] alu_res;
    logic [2*WIDTH-1:0] step_sum;
    logic [2*WIDTH-1:0] mcand;       // multiplicand, shifted left each step
    logic [2*WIDTH-1:0] acc;         // running partial product
    logic [WIDTH-1:0]   mplier;      // multiplier, shifted right each step
    logic [CW-1:0]      cnt;
    logic [1:0]         op_q;

    assign accept    = in_valid && (state == IDLE);
    assign last_step = (cnt == CW'(WIDTH - 1));
    assign step_sum  = acc + (mplier[0] ? mcand : '0);

`ifdef ALU_RESPONDER_FAST_MUL_EN
    assign mul_iter = 1'b0;
`else
    assign mul_iter = (op == OP_MUL);
`endif

    // Single-cycle result for the operands presented at the accepting edge
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD: alu_res = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
            OP_XOR: alu_res = {{WIDTH{1'b0}}, a ^ b};
            OP_AND: alu_res = {{WIDTH{1'b0}}, a & b};
`ifdef ALU_RESPONDER_FAST_MUL_EN
            OP_MUL: alu_res = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif
            default: alu_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) state_nx = mul_iter ? EXEC : DONE;
            end
            EXEC: begin
                if (last_step) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add steps, result load on DONE entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            cnt       <= '0;
            op_q      <= 2'b00;
            result    <= '0;
            result_op <= 2'b00;
        end else if (accept) begin
            op_q   <= op;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            if (!mul_iter) begin
                result    <= alu_res;
                result_op <= op;
            end
        end else if (state == EXEC) begin
            acc    <= step_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last_step) begin
                result    <= step_sum;
                result_op <= op_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_responder.sv
// Bench for alu_responder (WIDTH=8). It runs a vector table through a common
// handshake task, then hand-written sequences for back-to-back, backpressure
// and reset corner cases. Define ALU_RESPONDER_FAST_MUL_EN to expect the
// one-cycle MUL latency.
module tb_alu_responder;

    localparam int W = 8;
`ifdef ALU_RESPONDER_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif

    logic           clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]     op, result_op;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] result;

    int checks = 0;
    int errors = 0;

    alu_responder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_op(result_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]     op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] res;
        int             lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one op, scramble the inputs while it is busy, then check the
    // latency, result and completion. out_ready must be 1 when this is called.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [2*W-1:0] er, input int el);
        int lat;
        bit bad;
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); op = 2'($urandom);
        lat = 1;
        bad = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) bad = 1'b1;
            @(negedge clk);
            lat++;
            a = W'($urandom); b = W'($urandom); in_valid = 1'($urandom);
        end
        in_valid = 1'b0;
        chk("latency", lat, el);
        chk("result", result, er);
        chk("result_op", result_op, o);
        chk("in_ready_busy", bad, 0);
        chk("in_ready_done", in_ready, 0);
        @(negedge clk);
        chk("out_valid_after", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
    endtask

    initial begin
        vecs[0]  = '{2'b00, 8'hFF, 8'h01, 16'h0100, 1};
        vecs[1]  = '{2'b10, 8'hFF, 8'hFF, 16'hFE01, MUL_LAT};
        vecs[2]  = '{2'b01, 8'hA5, 8'h0F, 16'h00AA, 1};
        vecs[3]  = '{2'b11, 8'hA5, 8'h0F, 16'h0005, 1};
        vecs[4]  = '{2'b10, 8'h03, 8'h05, 16'h000F, MUL_LAT};
        vecs[5]  = '{2'b00, 8'h7F, 8'h80, 16'h00FF, 1};
        vecs[6]  = '{2'b10, 8'h00, 8'hFF, 16'h0000, MUL_LAT};
        vecs[7]  = '{2'b10, 8'h80, 8'h02, 16'h0100, MUL_LAT};
        vecs[8]  = '{2'b10, 8'h12, 8'h34, 16'h03A8, MUL_LAT};
        vecs[9]  = '{2'b10, 8'hAB, 8'hCD, 16'h88EF, MUL_LAT};
        vecs[10] = '{2'b01, 8'hFF, 8'hFF, 16'h0000, 1};
        vecs[11] = '{2'b00, 8'hFF, 8'hFF, 16'h01FE, 1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 2'b00; a = '0; b = '0;
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_result_op", result_op, 0);

        // Deassert reset with an ADD already presented: it must be taken on the first edge
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b1; op = 2'b00; a = 8'hFF; b = 8'h01;
        @(negedge clk);
        in_valid = 1'b0;
        chk("first_accept_valid", out_valid, 1);
        chk("first_accept_result", result, 16'h0100);
        @(negedge clk);
        chk("first_accept_done", out_valid, 0);

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

        // Back-to-back XOR then AND with in_valid held high
        @(negedge clk);
        in_valid = 1'b1; op = 2'b01; a = 8'hA5; b = 8'h0F;
        @(negedge clk);
        chk("b2b_xor_valid", out_valid, 1);
        chk("b2b_xor_result", result, 16'h00AA);
        chk("b2b_no_accept_done", in_ready, 0);
        op = 2'b11;
        @(negedge clk);
        chk("b2b_idle_ready", in_ready, 1);
        chk("b2b_idle_valid", out_valid, 0);
        chk("b2b_idle_hold", result, 16'h00AA);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_and_valid", out_valid, 1);
        chk("b2b_and_result", result, 16'h0005);
        chk("b2b_and_op", result_op, 2'b11);
        @(negedge clk);

        // Backpressure: hold the ADD result for 5 cycles with junk on the inputs
        out_ready = 1'b0;
        in_valid = 1'b1; op = 2'b00; a = 8'h10; b = 8'h20;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
            chk("bp_valid", out_valid, 1);
            chk("bp_ready", in_ready, 0);
            chk("bp_result", result, 16'h0030);
            chk("bp_op", result_op, 2'b00);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);

        // Reset in EXEC cycle 3 of MUL 0x12*0x34
        in_valid = 1'b1; op = 2'b10; a = 8'h12; b = 8'h34;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_exec_ready", in_ready, 1);
        chk("rst_exec_valid", out_valid, 0);
        chk("rst_exec_result", result, 0);
        chk("rst_exec_op", result_op, 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 14; i++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            chk("rst_exec_no_result", seen, 0);
        end
        run_op(2'b00, 8'h01, 8'h01, 16'h0002, 1);

        // Reset while a result is held in DONE
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; op = 2'b01; a = 8'h3C; b = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_done_pre", result, 16'h00C3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_done_valid", out_valid, 0);
        chk("rst_done_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_done_stay_idle", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: timeout got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
